// File: rtl/gb_pkg.sv
// Shared types and helpers for the sequential Gray-to-binary decoder.
// The GRAY_TO_BIN_FAST_EN build of gray_to_bin_seq uses gray2bin as its single-cycle datapath.
package gb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'b00;
   localparam state_t CONV = 2'b01;
   localparam state_t DONE = 2'b10;

   localparam int GB_DEFAULT_WIDTH = 4;

   // Prefix-XOR from the MSB down; narrower words are zero-extended, leaving low bits exact.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder: one bit per clock, MSB first, registered result with done pulse.
// Define GRAY_TO_BIN_FAST_EN to resolve all bits in a single CONV cycle through the prefix-XOR chain.
module gray_to_bin_seq
   import gb_pkg::*;
#(
   parameter int WIDTH = GB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifndef GRAY_TO_BIN_FAST_EN
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   logic [IW-1:0]    idx_q, idx_d;
   logic             prev_q, prev_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bit_s;
`endif

   // Next-state and datapath logic for the conversion FSM.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      dout_d  = dout_q;
`ifndef GRAY_TO_BIN_FAST_EN
      idx_d   = idx_q;
      prev_d  = prev_q;
      res_d   = res_q;
      bit_s   = prev_q ^ g_q[idx_q];
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               g_d     = din;
               state_d = CONV;
`ifndef GRAY_TO_BIN_FAST_EN
               idx_d   = IW'(WIDTH - 1);
               prev_d  = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
`ifdef GRAY_TO_BIN_FAST_EN
            dout_d  = WIDTH'(gray2bin(32'(g_q)));
            state_d = DONE;
`else
            res_d[idx_q] = bit_s;
            prev_d       = bit_s;
            // dout only ever takes a fully resolved word.
            if (idx_q == '0) begin
               dout_d  = res_d;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State, captured Gray word and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifndef GRAY_TO_BIN_FAST_EN
         idx_q   <= '0;
         prev_q  <= 1'b0;
         res_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifndef GRAY_TO_BIN_FAST_EN
         idx_q   <= idx_d;
         prev_q  <= prev_d;
         res_q   <= res_d;
`endif
      end
   end

   assign dout = dout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Self-checking bench for gray_to_bin_seq: directed cases, round-trip sweep and random traffic
// against a cycle-count reference model.
module tb_gray_to_bin_seq;

   localparam int WIDTH = 4;
`ifdef GRAY_TO_BIN_FAST_EN
   localparam int LAT = 1;
`else
   localparam int LAT = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             busy;
   logic             done;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: cycles remaining until the decoder is idle again, plus expected dout.
   int               rem = 0;
   logic [WIDTH-1:0] cap = '0;
   logic [WIDTH-1:0] exp_dout = '0;

   gray_to_bin_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .dout  (dout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_decode(input logic [WIDTH-1:0] g);
      int v;
      v = int'(g);
      for (int s = 1; s < 32; s = s * 2) v = v ^ (v >> s);
      return WIDTH'(v);
   endfunction

   function automatic logic [WIDTH-1:0] ref_encode(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         rem      = 0;
         exp_dout = '0;
      end else if (rem == 0) begin
         if (start) begin
            cap = din;
            rem = LAT + 1;
         end
      end else begin
         rem--;
         if (rem == 1) exp_dout = ref_decode(cap);
      end
      #1;
      chk("dout", 32'(dout), 32'(exp_dout));
      chk("busy", 32'(busy), 32'(rem != 0));
      chk("done", 32'(done), 32'(rem == 1));
   endtask

   // Start one conversion from IDLE, wait for done and compare against an independent constant.
   task automatic run_conv(input string tag, input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] expect_b);
      logic seen;
      int   width_cnt;
      start = 1'b1;
      din   = g;
      tick();
      start = 1'b0;
      din   = WIDTH'($urandom);
      seen  = 1'b0;
      width_cnt = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            chk(tag, 32'(dout), 32'(expect_b));
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      while (done && width_cnt < 5) begin
         width_cnt++;
         tick();
      end
      chk("done_width", 32'(width_cnt), 32'd1);
   endtask

   initial begin
      // Reset held: start toggling must have no effect.
      din = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         start = i[0];
         tick();
      end
      chk("rst_dout", 32'(dout), 32'd0);

      // Start already high on the first edge after release.
      start = 1'b1;
      din   = 4'b0010;
      rst   = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < LAT + 1; i++) tick();
      chk("basic_0010", 32'(dout), 32'h3);
      tick();

      run_conv("basic_0111", 4'b0111, 4'b0101);
      run_conv("edge_0000", 4'b0000, 4'b0000);
      run_conv("edge_1000", 4'b1000, 4'b1111);
      run_conv("edge_1100", 4'b1100, 4'b1000);

      // Start held high; din changes mid-conversion.
      start = 1'b1;
      din   = 4'b0010;
      tick();
      din   = 4'b0111;
      for (int i = 0; i < 3 * (LAT + 2); i++) tick();
      start = 1'b0;
      for (int i = 0; i < LAT + 2; i++) tick();

      // Reset during the second CONV cycle.
      start = 1'b1;
      din   = 4'b0111;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      rem = 0;
      exp_dout = '0;
      chk("rst_async_dout", 32'(dout), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < LAT + 3; i++) tick();

      // Round trip through the encoder for every value.
      for (int b = 0; b < 16; b++) begin
         run_conv("roundtrip", ref_encode(4'(b)), 4'(b));
      end

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         start = 1'($urandom_range(0, 1));
         din   = WIDTH'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            rem = 0;
            exp_dout = '0;
            chk("rnd_rst_busy", 32'(busy), 32'd0);
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
